// File: rtl/alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_ctrl_pkg
// Purpose  : Opcodes, FSM states, alu_sel bit positions and flag indices
//            shared by the logic_unit front end.
// Revision : 1.0
// ============================================================================
package alu_ctrl_pkg;

    localparam int OP_PASS = 0;
    localparam int OP_ADD  = 1;
    localparam int OP_SUB  = 2;
    localparam int OP_SHR  = 3;
    localparam int OP_SHL  = 4;
    localparam int OP_AND  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_XOR  = 7;
    localparam int OP_NOT  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // One-hot select lines of logic_unit, LSB first
    localparam int SEL_PASS = 0;
    localparam int SEL_ADD  = 1;
    localparam int SEL_SUB  = 2;
    localparam int SEL_SHR  = 3;
    localparam int SEL_SHL  = 4;
    localparam int SEL_AND  = 5;
    localparam int SEL_OR   = 6;
    localparam int SEL_XOR  = 7;
    localparam int SEL_NOT  = 8;
    localparam int SEL_W    = 9;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-way round-robin grant; a contested grant goes to the
//            requester that did not win the previous accept.
// Revision : 1.0
// ============================================================================
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic r_last_grant;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = r_last_grant ? 2'b01 : 2'b10;
        end
    end

    // Reset to 1 so that requester 0 wins the first contested grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (accept) begin
            r_last_grant <= grant[1];
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Shares one logic_unit between two valid/ready requesters and
//            returns the result with {V,C,N,Z} flags on a tagged response.
// Revision : 1.0
// ============================================================================
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int DW  = 16,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [OPW-1:0] req_op0,
    input  logic [OPW-1:0] req_op1,
    input  logic [DW-1:0]  req_a0,
    input  logic [DW-1:0]  req_a1,
    input  logic [DW-1:0]  req_b0,
    input  logic [DW-1:0]  req_b1,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           resp_id,
    output logic [DW-1:0]  resp_data,
    output logic [3:0]     resp_flags,
    output logic           resp_err,
    output logic [8:0]     alu_sel,
    output logic [DW-1:0]  alu_bus1,
    output logic [DW-1:0]  alu_bus2,
    input  logic [DW-1:0]  alu_bus3
);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     w_grant;
    logic           w_accept;
    logic           w_exec;

    logic           r_id;
    logic [OPW-1:0] r_op;
    logic [DW-1:0]  r_a;
    logic [DW-1:0]  r_b;

    logic [8:0]     w_sel;
    logic           w_legal;
    logic [DW-1:0]  w_result;
    logic           w_carry;
    logic           w_ovf;
    logic [3:0]     w_flags;

    logic           r_resp_id;
    logic [DW-1:0]  r_resp_data;
    logic [3:0]     r_resp_flags;
    logic           r_resp_err;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .accept (w_accept),
        .grant  (w_grant)
    );

    assign req_ready = (r_state == ST_IDLE) ? w_grant : 2'b00;
    assign w_accept  = |(req_valid & req_ready);
    assign w_exec    = (r_state == ST_EXEC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)   w_state_nxt = ST_EXEC;
            ST_EXEC:                 w_state_nxt = ST_RESP;
            ST_RESP: if (resp_ready) w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id <= 1'b0;
            r_op <= '0;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_accept) begin
            r_id <= w_grant[1];
            r_op <= w_grant[1] ? req_op1 : req_op0;
            r_a  <= w_grant[1] ? req_a1  : req_a0;
            r_b  <= w_grant[1] ? req_b1  : req_b0;
        end
    end

    always_comb begin
        w_sel   = '0;
        w_legal = 1'b1;
        case (r_op)
            OPW'(OP_PASS): w_sel[SEL_PASS] = 1'b1;
            OPW'(OP_ADD):  w_sel[SEL_ADD]  = 1'b1;
            OPW'(OP_SUB):  w_sel[SEL_SUB]  = 1'b1;
            OPW'(OP_SHR):  w_sel[SEL_SHR]  = 1'b1;
            OPW'(OP_SHL):  w_sel[SEL_SHL]  = 1'b1;
            OPW'(OP_AND):  w_sel[SEL_AND]  = 1'b1;
            OPW'(OP_OR):   w_sel[SEL_OR]   = 1'b1;
            OPW'(OP_XOR):  w_sel[SEL_XOR]  = 1'b1;
            OPW'(OP_NOT):  w_sel[SEL_NOT]  = 1'b1;
            default:       w_legal         = 1'b0;
        endcase
    end

    assign alu_sel  = w_exec ? w_sel : '0;
    assign alu_bus1 = w_exec ? r_a   : '0;
    assign alu_bus2 = w_exec ? r_b   : '0;

    // logic_unit only returns r; carry and overflow come from the latched operands
    always_comb begin
        w_carry  = 1'b0;
        w_ovf    = 1'b0;
        w_result = w_legal ? alu_bus3 : '0;
        case (r_op)
            OPW'(OP_ADD): begin
                w_carry = ({1'b0, r_a} + {1'b0, r_b}) > {1'b0, {DW{1'b1}}};
                w_ovf   = (r_a[DW-1] == r_b[DW-1]) && (alu_bus3[DW-1] != r_a[DW-1]);
            end
            OPW'(OP_SUB): begin
                w_carry = (r_a < r_b);
                w_ovf   = (r_a[DW-1] != r_b[DW-1]) && (alu_bus3[DW-1] != r_a[DW-1]);
            end
            default: begin
            end
        endcase
        w_flags         = '0;
        w_flags[FLAG_Z] = w_legal && (w_result == '0);
        w_flags[FLAG_N] = w_result[DW-1];
        w_flags[FLAG_C] = w_carry;
        w_flags[FLAG_V] = w_ovf;
    end

    // Response registers hold steady for the whole RESP phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_id    <= 1'b0;
            r_resp_data  <= '0;
            r_resp_flags <= '0;
            r_resp_err   <= 1'b0;
        end else if (w_exec) begin
            r_resp_id    <= r_id;
            r_resp_data  <= w_result;
            r_resp_flags <= w_flags;
            r_resp_err   <= ~w_legal;
        end
    end

    assign resp_valid = (r_state == ST_RESP);
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;
    assign resp_flags = r_resp_flags;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Self-checking bench for alu_arbiter with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_alu_arbiter;

    localparam int DW  = 16;
    localparam int OPW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [1:0]     req_valid = 2'b00;
    logic [1:0]     req_ready;
    logic [OPW-1:0] req_op0 = '0, req_op1 = '0;
    logic [DW-1:0]  req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
    logic           resp_valid, resp_id, resp_err;
    logic           resp_ready = 1'b0;
    logic [DW-1:0]  resp_data;
    logic [3:0]     resp_flags;
    logic [8:0]     alu_sel;
    logic [DW-1:0]  alu_bus1, alu_bus2, alu_bus3;
    logic [DW-1:0]  float_val = 16'hDEAD;

    int total = 0;
    int bad   = 0;

    // transaction-level model
    int          m_last;
    bit          m_busy;
    int          m_age;
    int          m_id, m_op;
    logic [15:0] m_a, m_b;
    logic [20:0] m_exp;
    bit          m_acc;
    int          m_acc_id;
    logic [1:0]  s_ready, s_valid, obs_acc;

    always #5 clk = ~clk;

    alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_data(resp_data), .resp_flags(resp_flags), .resp_err(resp_err),
        .alu_sel(alu_sel), .alu_bus1(alu_bus1), .alu_bus2(alu_bus2), .alu_bus3(alu_bus3)
    );

    // stand-in for logic_unit; floats to junk when nothing is selected
    always_comb begin
        case (alu_sel)
            9'h001:  alu_bus3 = alu_bus1;
            9'h002:  alu_bus3 = alu_bus1 + alu_bus2;
            9'h004:  alu_bus3 = alu_bus1 - alu_bus2;
            9'h008:  alu_bus3 = (alu_bus2 >= 16) ? 16'h0 : (alu_bus1 >> alu_bus2);
            9'h010:  alu_bus3 = (alu_bus2 >= 16) ? 16'h0 : (alu_bus1 << alu_bus2);
            9'h020:  alu_bus3 = alu_bus1 & alu_bus2;
            9'h040:  alu_bus3 = alu_bus1 | alu_bus2;
            9'h080:  alu_bus3 = alu_bus1 ^ alu_bus2;
            9'h100:  alu_bus3 = ~alu_bus1;
            default: alu_bus3 = float_val;
        endcase
    end

    // returns {err, V, C, N, Z, data}
    function automatic logic [20:0] ref_op(input int op, input logic [15:0] a, input logic [15:0] b);
        int ua, ub, sa, sb, full;
        logic [15:0] r;
        bit c, v, err;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        c = 0; v = 0; err = 0; r = 16'h0;
        case (op)
            0: r = a;
            1: begin full = ua + ub; r = 16'(full); c = (full > 65535);
                     v = (sa + sb > 32767) || (sa + sb < -32768); end
            2: begin r = 16'(ua - ub); c = (ua < ub);
                     v = (sa - sb > 32767) || (sa - sb < -32768); end
            3: r = (ub >= 16) ? 16'h0 : 16'(ua >> ub);
            4: r = (ub >= 16) ? 16'h0 : 16'(ua << ub);
            5: r = a & b;
            6: r = a | b;
            7: r = a ^ b;
            8: r = ~a;
            default: err = 1;
        endcase
        return {err, v, c, r[15], (r == 16'h0) && !err, r};
    endfunction

    function automatic logic [1:0] exp_ready_f();
        if (m_busy) return 2'b00;
        if (req_valid == 2'b11) return (m_last == 1) ? 2'b01 : 2'b10;
        return req_valid;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = 1; m_busy = 0; m_age = 0; m_acc = 0; m_acc_id = 0;
    endtask

    task automatic check_cycle();
        bit exec, resp;
        exec = m_busy && (m_age == 1);
        resp = m_busy && (m_age >= 2);
        s_ready = req_ready;
        s_valid = req_valid;
        chk("req_ready", req_ready, exp_ready_f());
        chk("alu_sel", alu_sel, (exec && m_op < 9) ? (32'h1 << m_op) : 32'h0);
        if (exec) begin
            chk("alu_bus1", alu_bus1, m_a);
            chk("alu_bus2", alu_bus2, m_b);
        end
        chk("resp_valid", resp_valid, resp);
        if (resp) begin
            chk("resp_id", resp_id, m_id);
            chk("resp_data", resp_data, m_exp[15:0]);
            chk("resp_flags", resp_flags, m_exp[19:16]);
            chk("resp_err", resp_err, m_exp[20]);
        end
    endtask

    task automatic model_update();
        logic [1:0] g;
        m_acc = 0;
        if (m_busy) begin
            if (m_age == 1) m_age = 2;
            else if (resp_ready) m_busy = 0;
        end else begin
            g = exp_ready_f() & req_valid;
            if (g != 2'b00) begin
                m_acc = 1; m_acc_id = g[1] ? 1 : 0; m_last = m_acc_id;
                m_busy = 1; m_age = 1; m_id = m_acc_id;
                m_op = g[1] ? int'(req_op1) : int'(req_op0);
                m_a  = g[1] ? req_a1 : req_a0;
                m_b  = g[1] ? req_b1 : req_b0;
                m_exp = ref_op(m_op, m_a, m_b);
            end
        end
    endtask

    // check at the falling edge, advance the model at the rising edge
    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        model_update();
        #1;
        obs_acc = s_ready & s_valid;
        float_val = 16'($urandom);
    endtask

    task automatic set_req(input int id, input int op, input logic [15:0] a, input logic [15:0] b);
        if (id == 0) begin req_op0 = OPW'(op); req_a0 = a; req_b0 = b; end
        else         begin req_op1 = OPW'(op); req_a1 = a; req_b1 = b; end
    endtask

    task automatic issue(input int id, input int op, input logic [15:0] a, input logic [15:0] b, output bit ok);
        set_req(id, op, a, b);
        req_valid[id] = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            if (obs_acc[id]) ok = 1;
        end
        req_valid[id] = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL issue_timeout: requester %0d never accepted", id);
        end
    endtask

    task automatic run_op(input int id, input int op, input logic [15:0] a, input logic [15:0] b,
                          input logic [8:0] esel, input logic [15:0] edata,
                          input logic [3:0] eflags, input logic eerr);
        bit ok;
        resp_ready = 1'b1;
        issue(id, op, a, b, ok);
        if (ok) begin
            chk("lit_sel", alu_sel, esel);
            chk("lit_rv_exec", resp_valid, 0);
            step();
            chk("lit_rv", resp_valid, 1);
            chk("lit_id", resp_id, id);
            chk("lit_data", resp_data, edata);
            chk("lit_flags", resp_flags, eflags);
            chk("lit_err", resp_err, eerr);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_alu_sel"}, alu_sel, 0);
        chk({tag, "_bus1"}, alu_bus1, 0);
        chk({tag, "_bus2"}, alu_bus2, 0);
        chk({tag, "_resp_id"}, resp_id, 0);
        chk({tag, "_resp_data"}, resp_data, 0);
        chk({tag, "_resp_flags"}, resp_flags, 0);
        chk({tag, "_resp_err"}, resp_err, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pick();
        case ($urandom % 6)
            0: return 16'h0000;
            1: return 16'h7FFF;
            2: return 16'h8000;
            3: return 16'hFFFF;
            4: return 16'($urandom % 20);
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        bit ok;
        int n;
        int ids[4];
        model_reset();
        #1;
        check_reset_outputs("rst");
        repeat (2) @(negedge clk);
        release_reset();

        run_op(0, 1, 16'h7FFF, 16'h0001, 9'h002, 16'h8000, 4'b1010, 1'b0);
        run_op(1, 2, 16'h0003, 16'h0005, 9'h004, 16'hFFFE, 4'b0110, 1'b0);
        run_op(1, 4, 16'h0001, 16'd16,   9'h010, 16'h0000, 4'b0001, 1'b0);

        // both requesters valid continuously
        resp_ready = 1'b1;
        set_req(0, 1, 16'h0001, 16'h0002);
        set_req(1, 7, 16'h00FF, 16'h0F0F);
        req_valid = 2'b11;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            step();
            if (obs_acc != 2'b00) begin ids[n] = obs_acc[1] ? 1 : 0; n++; end
        end
        req_valid = 2'b00;
        chk("alt_count", n, 4);
        chk("alt_0", ids[0], 0);
        chk("alt_1", ids[1], 1);
        chk("alt_2", ids[2], 0);
        chk("alt_3", ids[3], 1);
        repeat (3) step();

        // back-pressure on the response
        resp_ready = 1'b0;
        issue(0, 6, 16'h0F00, 16'h00F0, ok);
        set_req(1, 1, 16'h1111, 16'h2222);
        req_valid[1] = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("hold_rv", resp_valid, 1);
            chk("hold_data", resp_data, 16'h0FF0);
            chk("hold_ready", req_ready, 0);
            step();
        end
        resp_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 6 && n == 0; i++) begin
            step();
            if (obs_acc != 2'b00) begin n = 1; chk("after_hold_acc", obs_acc, 2'b10); end
        end
        req_valid = 2'b00;
        chk("after_hold_seen", n, 1);
        repeat (3) step();

        run_op(0, 12, 16'h1234, 16'h5678, 9'h000, 16'h0000, 4'b0000, 1'b1);

        // reset during EXEC drops the op
        issue(1, 5, 16'hF0F0, 16'h3C3C, ok);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        release_reset();
        set_req(0, 0, 16'hAAAA, 16'h0);
        set_req(1, 8, 16'h5555, 16'h0);
        req_valid = 2'b11;
        n = 0;
        for (int i = 0; i < 6 && n == 0; i++) begin
            step();
            if (obs_acc != 2'b00) begin n = 1; chk("post_rst_grant", obs_acc, 2'b01); end
        end
        chk("post_rst_seen", n, 1);
        req_valid = 2'b00;
        repeat (4) step();

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            for (int r = 0; r < 2; r++) begin
                int op;
                op = ($urandom % 8 == 0) ? 9 + int'($urandom % 7) : int'($urandom % 9);
                set_req(r, op, pick(), pick());
                req_valid[r] = ($urandom % 3) != 0;
            end
            resp_ready = ($urandom % 5) < 3;
            step();
        end
        req_valid = 2'b00;
        resp_ready = 1'b1;
        repeat (6) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single 16-bit `logic_unit` between two requesters, e.g. the execute stage and the address-generation path. Each requester presents an opcode and two operands on a valid/ready handshake. A round-robin grant selects one request and latches it, then drives the one-hot select lines and operand buses of `logic_unit` for one cycle. The block registers the result with Z/N/C/V flags and returns it on a response handshake tagged with the requester id.

## Interface
- `DW`, default 16: datapath width; must match `logic_unit`.
- `OPW`, default 4: opcode width.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  2  per-requester request valid; bit i belongs to requester i.
- `req_ready`  out  2  per-requester accept; a request transfers when valid[i] and ready[i] are both high on a clock edge.
- `req_op0` / `req_op1`  in  OPW  opcode per requester.
- `req_a0` / `req_a1`, `req_b0` / `req_b1`  in  DW  operands per requester.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts the result.
- `resp_id`  out  1  requester that issued the result.
- `resp_data`  out  DW  result.
- `resp_flags`  out  4  {V,C,N,Z}.
- `resp_err`  out  1  illegal opcode.
- `alu_sel`  out  9  one-hot {bnegate,bxor,bor,band,shl,shr,sub,add,passthrough}, driven to `logic_unit`.
- `alu_bus1` / `alu_bus2`  out  DW  operands driven to `logic_unit`.
- `alu_bus3`  in  DW  result returned from `logic_unit`.

## Operation
- Opcodes: 0 PASS, 1 ADD, 2 SUB, 3 SHR, 4 SHL, 5 AND, 6 OR, 7 XOR, 8 NOT. Codes 9–15 are illegal.
- FSM states:
  - IDLE: accept a request. On accept, latch id, op, a and b, then go to EXEC.
  - EXEC: drive `alu_sel` from the latched op, with `alu_bus1`=a and `alu_bus2`=b. Capture `alu_bus3` and compute flags, then go to RESP.
  - RESP: hold `resp_valid`=1 until `resp_ready`, then go to IDLE.
- Arbitration:
  - `last_grant` register resets to 1, so requester 0 wins first.
  - With both requesters valid in IDLE, grant goes to ~last_grant.
  - With one valid, that requester is granted.
  - `last_grant` updates on every accept.
- `req_ready[i]`: combinational, and high only in IDLE for the granted requester.
  - Both bits are 0 in EXEC and RESP.
  - Never both high in the same cycle.
- Illegal opcode:
  - EXEC drives `alu_sel`=0.
  - Result: `resp_data`=0, `resp_flags`=0, `resp_err`=1.
- Flags:
  - Z = (result==0); N = result[DW-1].
  - ADD: C = carry out of the (DW+1)-bit a+b; V = (a[15]==b[15]) && (r[15]!=a[15]).
  - SUB: C = borrow (a<b, unsigned); V = (a[15]!=b[15]) && (r[15]!=a[15]).
  - All other opcodes: C = V = 0.
  - The block computes C and V itself from the latched operands; `logic_unit` provides only r.
- Shifts take the full 16-bit b as the shift count; a count ≥16 gives 0.
- Outside EXEC, `alu_sel`=0 and `alu_bus3` is ignored (it floats).
- Response outputs are stable from the first cycle of `resp_valid` until the handshake completes.

## Timing
- Reset values:
  - state IDLE, `last_grant`=1.
  - `req_ready`=0 is combinational, so it can rise in the first cycle after reset if a request is valid.
  - `resp_valid`=0; `resp_id`, `resp_data`, `resp_flags`, `resp_err` all 0.
  - `alu_sel`=0, `alu_bus1`=0, `alu_bus2`=0.
- Latency: accept edge T, EXEC during cycle T+1, `resp_valid` high from T+2.
- Back-to-back: a request can be accepted in the cycle after the response handshake, giving a minimum of 3 cycles per op.
- `resp_ready` high on the first RESP cycle means one RESP cycle only.
- Reset asserted mid-EXEC or mid-RESP drops the in-flight op: no response is produced and all outputs return to reset values asynchronously.
- A requester deasserting valid while not granted is legal and has no effect.

## Structure
- Package `alu_ctrl_pkg` holds:
  - opcode localparams;
  - FSM state encodings (IDLE, EXEC, RESP);
  - `alu_sel` bit positions;
  - flag bit indices (Z=0, N=1, C=2, V=3).
- Sub-module `rr_arb2`: two-way round-robin grant holding `last_grant`, with `req`, `accept` and `grant` ports.
- Opcode-to-one-hot decode and flag logic stay in `alu_arbiter`.
- `logic_unit` is instantiated at the parent level, not inside `alu_arbiter`.

## Test plan
- Req0 ADD a=0x7FFF, b=0x0001 with `resp_ready`=1 -> response 2 cycles after accept: data 0x8000, flags V=1 N=1 C=0 Z=0, id 0.
- Req1 SUB a=0x0003, b=0x0005 -> data 0xFFFE, C=1 N=1, id 1. Then SHL a=0x0001, b=16 -> data 0x0000, Z=1.
- Both requesters valid continuously -> grants alternate 0,1,0,1. Each requester sees `req_ready` only on its own accept cycle.
- `resp_ready` held low for 5 cycles -> `resp_valid` and data stable throughout, `req_ready`=0, no new accept until the handshake.
- Opcode 12 -> `alu_sel`=0 in EXEC, response data 0, flags 0, `resp_err`=1.
- `rst_n` pulsed low during EXEC -> outputs reset immediately, no response. After release, requester 0 wins the first contested grant.
